// File: rtl/dmem_mmio_pkg.sv
// -----------------------------------------------------------------------------
// dmem_mmio_pkg
// Shared constants for the data-memory / memory-mapped I/O stage:
//   - IO_BASE_HI   : addr[31:16] value that selects the I/O block
//   - OFF_*        : byte offsets of the I/O registers inside the I/O block
//   - CTRL_*       : bit positions inside TIMER_CTRL
// No ports (package).
// -----------------------------------------------------------------------------
package dmem_mmio_pkg;

    localparam logic [15:0] IO_BASE_HI   = 16'hFFFF;

    localparam logic [15:0] OFF_GPIO_OUT = 16'h0000;
    localparam logic [15:0] OFF_GPIO_IN  = 16'h0004;
    localparam logic [15:0] OFF_TCNT     = 16'h0008;
    localparam logic [15:0] OFF_TCMP     = 16'h000C;
    localparam logic [15:0] OFF_TCTRL    = 16'h0010;

    localparam int CTRL_EN         = 0;
    localparam int CTRL_AUTORELOAD = 1;
    localparam int CTRL_IRQ_EN     = 2;
    localparam int CTRL_FLAG       = 3;

    // Register offsets compared as word indices, since addr[1:0] is ignored.
    function automatic logic [13:0] off_word(input logic [15:0] off);
        return off[15:2];
    endfunction

endpackage

// File: rtl/dmem_timer.sv
// -----------------------------------------------------------------------------
// dmem_timer
// Compare-match timer holding TIMER_CNT, TIMER_CMP, TIMER_CTRL and the match
// flag. Register writes arrive as one-hot strobes sharing one data bus; the
// read mux lives in the parent.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   cnt_we/cmp_we/ctrl_we  write strobes for CNT / CMP / CTRL
//   wdata[31:0]         write data
//   cnt, cmp, ctrl      register readback (ctrl includes the flag in bit 3)
//   irq                 flag AND irq_en, from registered state only
// -----------------------------------------------------------------------------
module dmem_timer
    import dmem_mmio_pkg::*;
#(
    parameter logic [31:0] CMP_RESET = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cnt_we,
    input  logic        cmp_we,
    input  logic        ctrl_we,
    input  logic [31:0] wdata,
    output logic [31:0] cnt,
    output logic [31:0] cmp,
    output logic [31:0] ctrl,
    output logic        irq
);

    logic en;
    logic autoreload;
    logic irq_en;
    logic flag;
    logic match;

    // Compare always uses the registered CMP, so a CMP write only affects
    // matching from the following cycle.
    assign match = en && (cnt == cmp);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            cmp        <= CMP_RESET;
            en         <= 1'b0;
            autoreload <= 1'b0;
            irq_en     <= 1'b0;
            flag       <= 1'b0;
        end else begin
            // A software write to CNT overrides increment and reload.
            if (cnt_we) begin
                cnt <= wdata;
            end else if (en) begin
                if (match && autoreload) cnt <= '0;
                else                     cnt <= cnt + 32'd1;
            end

            if (cmp_we) cmp <= wdata;

            if (ctrl_we) begin
                en         <= wdata[CTRL_EN];
                autoreload <= wdata[CTRL_AUTORELOAD];
                irq_en     <= wdata[CTRL_IRQ_EN];
            end

            // A new match beats a simultaneous write-1-to-clear.
            if (match)                              flag <= 1'b1;
            else if (ctrl_we && wdata[CTRL_FLAG])   flag <= 1'b0;
        end
    end

    always_comb begin
        ctrl                  = '0;
        ctrl[CTRL_EN]         = en;
        ctrl[CTRL_AUTORELOAD] = autoreload;
        ctrl[CTRL_IRQ_EN]     = irq_en;
        ctrl[CTRL_FLAG]       = flag;
    end

    assign irq = flag & irq_en;

endmodule

// File: rtl/dmem_mmio.sv
// -----------------------------------------------------------------------------
// dmem_mmio
// Data-memory stage for the single-cycle core: word-addressed RAM in the low
// address space, I/O block (GPIO out, synchronized GPIO in, timer) when
// addr[31:16] == 16'hFFFF. Reads are combinational; writes happen on the
// rising clock edge when memwrite is high.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   memwrite          store strobe
//   addr[31:0]        byte address (low two bits ignored)
//   writedata[31:0]   store data
//   readdata[31:0]    load data, combinational from addr
//   gpio_in           external asynchronous inputs
//   gpio_out          GPIO output register
//   irq               timer interrupt request
// -----------------------------------------------------------------------------
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int          RAM_WORDS = 64,
    parameter int          GPIO_W    = 16,
    parameter logic [31:0] CMP_RESET = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memwrite,
    input  logic [31:0]       addr,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              irq
);

    localparam int AW = $clog2(RAM_WORDS);

    logic              io_sel;
    logic [13:0]       io_word;
    logic [AW-1:0]     ram_idx;
    logic              io_we;
    logic [GPIO_W-1:0] gpio_sync1;
    logic [GPIO_W-1:0] gpio_sync2;
    logic [31:0]       gpio_out_ext;
    logic [31:0]       gpio_in_ext;
    logic [31:0]       tcnt;
    logic [31:0]       tcmp;
    logic [31:0]       tctrl;
    logic [31:0]       ram [RAM_WORDS];
    logic              unused_addr_lsbs;

    assign io_sel           = (addr[31:16] == IO_BASE_HI);
    assign io_word          = addr[15:2];
    // Upper address bits are not decoded, so the RAM aliases through the space.
    assign ram_idx          = addr[AW+1:2];
    assign io_we            = memwrite && io_sel;
    assign unused_addr_lsbs = ^addr[1:0];

    // RAM contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (memwrite && !io_sel) ram[ram_idx] <= writedata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpio_out   <= '0;
            gpio_sync1 <= '0;
            gpio_sync2 <= '0;
        end else begin
            if (io_we && io_word == off_word(OFF_GPIO_OUT))
                gpio_out <= writedata[GPIO_W-1:0];
            gpio_sync1 <= gpio_in;
            gpio_sync2 <= gpio_sync1;
        end
    end

    dmem_timer #(
        .CMP_RESET (CMP_RESET)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .cnt_we  (io_we && io_word == off_word(OFF_TCNT)),
        .cmp_we  (io_we && io_word == off_word(OFF_TCMP)),
        .ctrl_we (io_we && io_word == off_word(OFF_TCTRL)),
        .wdata   (writedata),
        .cnt     (tcnt),
        .cmp     (tcmp),
        .ctrl    (tctrl),
        .irq     (irq)
    );

    // Zero-extension written this way also works for GPIO_W == 32.
    always_comb begin
        gpio_out_ext             = '0;
        gpio_out_ext[GPIO_W-1:0] = gpio_out;
        gpio_in_ext              = '0;
        gpio_in_ext[GPIO_W-1:0]  = gpio_sync2;
    end

    always_comb begin
        readdata = '0;
        if (io_sel) begin
            if      (io_word == off_word(OFF_GPIO_OUT)) readdata = gpio_out_ext;
            else if (io_word == off_word(OFF_GPIO_IN))  readdata = gpio_in_ext;
            else if (io_word == off_word(OFF_TCNT))     readdata = tcnt;
            else if (io_word == off_word(OFF_TCMP))     readdata = tcmp;
            else if (io_word == off_word(OFF_TCTRL))    readdata = tctrl;
        end else begin
            readdata = ram[ram_idx];
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// -----------------------------------------------------------------------------
// tb_dmem_mmio
// Self-checking bench for dmem_mmio: a table of directed store/load vectors,
// hand-written timer/GPIO/reset sequences, then randomized traffic checked
// against a behavioural model of the memory map.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_mmio;

    localparam int RAM_WORDS = 64;
    localparam int GPIO_W    = 16;

    logic              clk;
    logic              reset;
    logic              memwrite;
    logic [31:0]       addr;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic [GPIO_W-1:0] gpio_in;
    logic [GPIO_W-1:0] gpio_out;
    logic              irq;

    int n_chk  = 0;
    int n_fail = 0;

    dmem_mmio #(
        .RAM_WORDS (RAM_WORDS),
        .GPIO_W    (GPIO_W),
        .CMP_RESET (32'hFFFF_FFFF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .addr      (addr),
        .writedata (writedata),
        .readdata  (readdata),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[$];

    // ---------------- behavioural reference model ----------------
    logic [31:0]       m_cnt, m_cmp;
    bit                m_en, m_au, m_ie, m_flag;
    logic [GPIO_W-1:0] m_gout;
    logic [GPIO_W-1:0] m_hist0, m_hist1;   // gpio_in at last edge, at edge before
    logic [31:0]       m_ram [RAM_WORDS];
    bit                m_val [RAM_WORDS];

    function automatic int ram_index(input logic [31:0] a);
        return int'((a % (RAM_WORDS * 4)) / 4);
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_cmp = 32'hFFFF_FFFF;
        m_en = 0; m_au = 0; m_ie = 0; m_flag = 0;
        m_gout = 0; m_hist0 = 0; m_hist1 = 0;
    endtask

    // Returns 1 when the expected value is defined (unwritten RAM is not).
    function automatic bit model_read(input logic [31:0] a, output logic [31:0] v);
        v = 0;
        if (a[31:16] != 16'hFFFF) begin
            v = m_ram[ram_index(a)];
            return m_val[ram_index(a)];
        end
        case (a[15:0] & 16'hFFFC)
            16'h0000: v = 32'(m_gout);
            16'h0004: v = 32'(m_hist1);
            16'h0008: v = m_cnt;
            16'h000C: v = m_cmp;
            16'h0010: v = {28'd0, m_flag, m_ie, m_au, m_en};
            default:  v = 0;
        endcase
        return 1;
    endfunction

    task automatic model_step(input logic we, input logic [31:0] a,
                              input logic [31:0] wd, input logic [GPIO_W-1:0] gin);
        bit          io;
        logic [15:0] off;
        bit          hit;
        logic [31:0] n_cnt;
        io  = (a[31:16] == 16'hFFFF);
        off = a[15:0] & 16'hFFFC;
        hit = m_en && (m_cnt == m_cmp);
        if (m_en) n_cnt = (hit && m_au) ? 32'd0 : m_cnt + 32'd1;
        else      n_cnt = m_cnt;
        if (we && io && off == 16'h0008) n_cnt = wd;
        if (hit) m_flag = 1;
        else if (we && io && off == 16'h0010 && wd[3]) m_flag = 0;
        if (we && io && off == 16'h000C) m_cmp = wd;
        if (we && io && off == 16'h0010) begin
            m_en = wd[0]; m_au = wd[1]; m_ie = wd[2];
        end
        if (we && io && off == 16'h0000) m_gout = wd[GPIO_W-1:0];
        if (we && !io) begin
            m_ram[ram_index(a)] = wd;
            m_val[ram_index(a)] = 1;
        end
        m_cnt   = n_cnt;
        m_hist1 = m_hist0;
        m_hist0 = gin;
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, want %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic sw(input logic [31:0] a, input logic [31:0] d);
        memwrite  = 1'b1;
        addr      = a;
        writedata = d;
        tick();
        memwrite  = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
        memwrite = 1'b0;
        addr     = a;
        #1;
        chk(name, readdata, exp);
    endtask

    task automatic add(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp, input string name);
        vec_t v;
        v.we = we; v.a = a; v.wd = wd; v.exp = exp; v.name = name;
        tbl.push_back(v);
    endtask

    initial begin
        reset = 1'b1; memwrite = 1'b0; addr = '0; writedata = '0; gpio_in = '0;
        for (int i = 0; i < RAM_WORDS; i++) m_val[i] = 0;
        model_reset();
        tick();
        tick();
        reset = 1'b0;
        tick();

        chk("reset_gpio_out", 32'(gpio_out), 32'd0);
        chk("reset_irq", 32'(irq), 32'd0);

        // ---------------- directed vector table ----------------
        add(1, 32'h0000_0040, 32'hDEAD_BEEF, 0,            "");
        add(0, 32'h0000_0040, 0,             32'hDEAD_BEEF, "ram_rd");
        add(0, 32'h0000_0140, 0,             32'hDEAD_BEEF, "ram_alias");
        add(0, 32'h0000_0042, 0,             32'hDEAD_BEEF, "ram_lowbits");
        add(1, 32'h0000_0020, 32'h1111_1111, 0,            "");
        add(1, 32'hFFFF_0000, 32'h0001_A5A5, 0,            "");
        add(0, 32'hFFFF_0000, 0,             32'h0000_A5A5, "gpio_out_rd");
        add(0, 32'hFFFF_0002, 0,             32'h0000_A5A5, "gpio_out_lowbits");
        add(1, 32'hFFFF_0004, 32'hFFFF_FFFF, 0,            "");
        add(0, 32'hFFFF_0004, 0,             32'h0000_0000, "gpio_in_ro");
        add(0, 32'hFFFF_0010, 0,             32'h0000_0000, "ctrl_reset");
        add(0, 32'hFFFF_000C, 0,             32'hFFFF_FFFF, "cmp_reset");
        add(0, 32'hFFFF_0008, 0,             32'h0000_0000, "cnt_reset");
        add(1, 32'hFFFF_0020, 32'h1234_5678, 0,            "");
        add(0, 32'hFFFF_0020, 0,             32'h0000_0000, "unmapped_rd");
        add(0, 32'h0000_0020, 0,             32'h1111_1111, "unmapped_no_ram");
        add(0, 32'h0000_0040, 0,             32'hDEAD_BEEF, "ram_rd_again");
        add(0, 32'hFFFF_0008, 0,             32'h0000_0000, "unmapped_no_cnt");

        foreach (tbl[i]) begin
            if (tbl[i].we) sw(tbl[i].a, tbl[i].wd);
            else           rd(tbl[i].a, tbl[i].exp, tbl[i].name);
        end
        chk("gpio_out_pin", 32'(gpio_out), 32'h0000_A5A5);

        // ---------------- GPIO input synchronizer latency ----------------
        tick();
        gpio_in = 16'h3C3C;
        rd(32'hFFFF_0004, 32'h0, "gpio_in_lat0");
        tick();
        rd(32'hFFFF_0004, 32'h0, "gpio_in_lat1");
        tick();
        rd(32'hFFFF_0004, 32'h0000_3C3C, "gpio_in_lat2");

        // ---------------- timer autoreload ----------------
        sw(32'hFFFF_000C, 32'd3);
        sw(32'hFFFF_0010, 32'h7);
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) tick();
            rd(32'hFFFF_0008, 32'(i % 4), "tmr_cnt_seq");
            chk("tmr_irq_seq", 32'(irq), (i >= 4) ? 32'd1 : 32'd0);
        end

        // ---------------- W1C away from and on a match ----------------
        sw(32'hFFFF_0010, 32'hF);               // CNT 0 -> 1, no match
        rd(32'hFFFF_0010, 32'h7, "w1c_clear_ctrl");
        chk("w1c_clear_irq", 32'(irq), 32'd0);
        tick();
        tick();
        rd(32'hFFFF_0008, 32'd3, "w1c_pre_match_cnt");
        sw(32'hFFFF_0010, 32'hF);               // coincides with CNT == CMP
        rd(32'hFFFF_0010, 32'hF, "w1c_vs_match_ctrl");
        chk("w1c_vs_match_irq", 32'(irq), 32'd1);
        rd(32'hFFFF_0008, 32'd0, "w1c_vs_match_cnt");

        // ---------------- CNT write vs increment ----------------
        sw(32'hFFFF_0008, 32'h100);
        rd(32'hFFFF_0008, 32'h100, "cnt_write_wins");
        tick();
        rd(32'hFFFF_0008, 32'h101, "cnt_after_write");

        // ---------------- asynchronous reset mid-count ----------------
        sw(32'hFFFF_0000, 32'h0000_BEEF);
        chk("pre_reset_gpio", 32'(gpio_out), 32'h0000_BEEF);
        chk("pre_reset_irq", 32'(irq), 32'd1);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("areset_gpio_out", 32'(gpio_out), 32'd0);
        chk("areset_irq", 32'(irq), 32'd0);
        rd(32'hFFFF_0008, 32'd0, "areset_cnt");
        rd(32'hFFFF_000C, 32'hFFFF_FFFF, "areset_cmp");
        rd(32'hFFFF_0010, 32'd0, "areset_ctrl");
        rd(32'h0000_0040, 32'hDEAD_BEEF, "areset_ram_kept");
        tick();
        reset = 1'b0;
        gpio_in = '0;
        model_reset();
        tick();

        // ---------------- randomized traffic vs model ----------------
        for (int c = 0; c < 800; c++) begin
            logic        we;
            logic [31:0] a;
            logic [31:0] wd;
            logic [31:0] ev;
            int          k;
            we = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 2) == 0) begin
                a  = {16'($urandom_range(0, 16'hFFFE)), 16'($urandom)};
                wd = $urandom;
            end else begin
                k = $urandom_range(0, 6);
                case (k)
                    0: a = 32'hFFFF_0000;
                    1: a = 32'hFFFF_0004;
                    2: a = 32'hFFFF_0008;
                    3: a = 32'hFFFF_000C;
                    4: a = 32'hFFFF_0010;
                    5: a = 32'hFFFF_0020;
                    default: a = {16'hFFFF, 16'($urandom)};
                endcase
                a[1:0] = 2'($urandom);
                if (k == 2 || k == 3)
                    wd = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFE - $urandom_range(0, 3)
                                                     : 32'($urandom_range(0, 12));
                else if (k == 4)
                    wd = 32'($urandom_range(0, 15)) | (($urandom_range(0, 3) != 0) ? 32'd1 : 32'd0);
                else
                    wd = $urandom;
            end
            memwrite  = we;
            addr      = a;
            writedata = wd;
            gpio_in   = GPIO_W'($urandom);
            #1;
            if (model_read(a, ev)) chk("rand_readdata", readdata, ev);
            chk("rand_gpio_out", 32'(gpio_out), 32'(m_gout));
            chk("rand_irq", 32'(irq), 32'(m_flag & m_ie));
            model_step(we, a, wd, gpio_in);
            tick();
        end
        memwrite = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
